// File: rtl/ilv_pkg.sv
// Shared types, constants and lookups for the 802.16 OFDM (256-FFT) block interleaver.
package ilv_pkg;

  localparam int N_DATA_SC = 192;
  localparam int D         = 16;
  localparam int NCBPS_MAX = 1152;
  localparam int AW        = 11;
  localparam int QW        = 7;   // q = k/D reaches 71 for 64QAM
  localparam int RW        = 4;   // r = k mod D

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_16QAM = 2'd2,
    MOD_64QAM = 2'd3
  } mod_e;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_FILL = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  function automatic logic [2:0] ncpc_of(input mod_e m);
    case (m)
      MOD_BPSK:  return 3'd1;
      MOD_QPSK:  return 3'd2;
      MOD_16QAM: return 3'd4;
      default:   return 3'd6;
    endcase
  endfunction

  function automatic logic [1:0] s_of(input mod_e m);
    case (m)
      MOD_16QAM: return 2'd2;
      MOD_64QAM: return 2'd3;
      default:   return 2'd1;
    endcase
  endfunction

  function automatic logic [AW-1:0] ncbps_of(input mod_e m);
    return AW'(N_DATA_SC * int'(ncpc_of(m)));
  endfunction

  // Bit-serial remainder by 3; unrolls into a short chain of small adders.
  function automatic logic [1:0] mod3(input logic [QW-1:0] v);
    logic [2:0] t;
    logic [1:0] rem;
    rem = 2'd0;
    for (int i = QW - 1; i >= 0; i--) begin
      t = {rem, v[i]};
      if (t >= 3'd3) t = t - 3'd3;
      rem = t[1:0];
    end
    return rem;
  endfunction

endpackage

// File: rtl/ilv_addr_gen.sv
// Write-side address generator: maps write index k (as q = k/D, r = k mod D) to the
// two-step permuted bank address j for the current modulation.
module ilv_addr_gen
  import ilv_pkg::*;
(
  input  logic [QW-1:0] i_q,
  input  logic [RW-1:0] i_r,
  input  logic [1:0]    i_mod,
  output logic [AW-1:0] o_j
);

  mod_e          w_mod;
  logic [AW-1:0] w_rowlen;
  logic [AW-1:0] w_m;
  logic [1:0]    w_mq;
  logic [1:0]    w_rq;
  logic [1:0]    w_sel;

  always_comb begin
    w_mod    = mod_e'(i_mod);
    w_rowlen = ncbps_of(w_mod) / AW'(D);
    w_m      = w_rowlen * AW'(i_r) + AW'(i_q);
    // For s=3 the row length (72) and Ncbps are multiples of 3, so m mod 3 == q mod 3
    // and (m + Ncbps - r) mod 3 == (q - r) mod 3.
    w_mq  = mod3(i_q);
    w_rq  = mod3(QW'(i_r));
    w_sel = (w_mq >= w_rq) ? (w_mq - w_rq) : (w_mq + 2'd3 - w_rq);
    case (s_of(w_mod))
      2'd2:    o_j = {w_m[AW-1:1], w_m[0] ^ i_r[0]};
      2'd3:    o_j = w_m - AW'(w_mq) + AW'(w_sel);
      default: o_j = w_m;
    endcase
  end

endmodule

// File: rtl/ofdm_interleaver.sv
// Ping-pong 802.16 OFDM block interleaver: permuted writes, sequential reads.
// Build option ILV_BYPASS_EN adds a per-symbol `bypass` input for identity ordering.
//
// state    | meaning
// WR_IDLE  | waiting for bit k=0 of the next symbol; mod_sel/bypass sampled on its accept
// WR_FILL  | writing bits k=1..Ncbps-1 into bank wb at permuted addresses
// RD_IDLE  | output stage waiting for bank rb to become full
// RD_DRAIN | streaming bank rb addresses 1..Ncbps-1 through the output register
module ofdm_interleaver
  import ilv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
`ifdef ILV_BYPASS_EN
  input  logic       bypass,
`endif
  input  logic [1:0] mod_sel,
  input  logic       in_bits,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bits,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sos,
  output logic [1:0] out_mod
);

  wr_state_e     r_wr_state, w_wr_next;
  rd_state_e     r_rd_state, w_rd_next;

  logic [AW-1:0] r_k;
  logic [QW-1:0] r_q;
  logic [RW-1:0] r_r;
  logic          r_wb;
  logic          r_rb;
  logic [1:0]    r_full;
  logic [1:0]    r_wr_mod;
  logic [1:0]    r_bank_mod0;
  logic [1:0]    r_bank_mod1;
  logic [AW-1:0] r_rd_addr;
  logic          r_out_bits;
  logic          r_out_valid;
  logic          r_out_sos;
  logic [1:0]    r_out_mod;

  logic          r_bank0 [NCBPS_MAX];
  logic          r_bank1 [NCBPS_MAX];

  logic [1:0]    w_mod_cur;
  logic [AW-1:0] w_ncbps_wr;
  logic [AW-1:0] w_j;
  logic [AW-1:0] w_wr_addr;
  logic          w_accept;
  logic          w_last_wr;
  logic          w_fill_done;
  logic          w_byp_cur;

  logic [1:0]    w_rd_mod;
  logic [AW-1:0] w_ncbps_rd;
  logic          w_rd_bit;
  logic          w_adv;
  logic          w_load;
  logic          w_rd_done;

  // ---------------- write side ----------------
  always_comb begin
    w_wr_next   = r_wr_state;
    w_mod_cur   = (r_wr_state == WR_IDLE) ? mod_sel : r_wr_mod;
    w_ncbps_wr  = ncbps_of(mod_e'(w_mod_cur));
    w_accept    = in_valid && !r_full[r_wb];
    w_last_wr   = (r_k == w_ncbps_wr - AW'(1));
    w_fill_done = w_accept && w_last_wr;
    case (r_wr_state)
      WR_IDLE: if (w_accept) w_wr_next = WR_FILL;
      WR_FILL: if (w_fill_done) w_wr_next = WR_IDLE;
      default: w_wr_next = WR_IDLE;
    endcase
  end

  ilv_addr_gen u_addr_gen (
    .i_q   (r_q),
    .i_r   (r_r),
    .i_mod (w_mod_cur),
    .o_j   (w_j)
  );

`ifdef ILV_BYPASS_EN
  logic r_byp;

  assign w_byp_cur = (r_wr_state == WR_IDLE) ? bypass : r_byp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byp <= 1'b0;
    end else if (w_accept && (r_wr_state == WR_IDLE)) begin
      r_byp <= bypass;
    end
  end
`else
  assign w_byp_cur = 1'b0;
`endif

  assign w_wr_addr = w_byp_cur ? r_k : w_j;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_state  <= WR_IDLE;
      r_k         <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_wb        <= 1'b0;
      r_wr_mod    <= 2'd0;
      r_bank_mod0 <= 2'd0;
      r_bank_mod1 <= 2'd0;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_accept) begin
        if (r_wr_state == WR_IDLE) begin
          r_wr_mod <= mod_sel;
          if (r_wb) r_bank_mod1 <= mod_sel;
          else      r_bank_mod0 <= mod_sel;
        end
        if (w_last_wr) begin
          r_k  <= '0;
          r_q  <= '0;
          r_r  <= '0;
          r_wb <= ~r_wb;
        end else begin
          r_k <= r_k + AW'(1);
          r_r <= r_r + RW'(1);
          if (r_r == RW'(D - 1)) r_q <= r_q + QW'(1);
        end
      end
    end
  end

  // Banks are plain RAM: no reset, one write port and one read port each.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_wb) r_bank1[w_wr_addr] <= in_bits;
      else      r_bank0[w_wr_addr] <= in_bits;
    end
  end

  // A bank is freed as soon as its last bit has moved into the output register,
  // so the next full bank can follow on the very next handoff with no gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 2'b00;
    end else begin
      if (w_fill_done) r_full[r_wb] <= 1'b1;
      if (w_rd_done)   r_full[r_rb] <= 1'b0;
    end
  end

  // ---------------- read side ----------------
  always_comb begin
    w_rd_mod   = r_rb ? r_bank_mod1 : r_bank_mod0;
    w_ncbps_rd = ncbps_of(mod_e'(w_rd_mod));
    w_rd_bit   = r_rb ? r_bank1[r_rd_addr] : r_bank0[r_rd_addr];
    w_adv      = !r_out_valid || out_ready;
    w_rd_next  = r_rd_state;
    w_load     = 1'b0;
    w_rd_done  = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (r_full[r_rb] && w_adv) begin
          w_load    = 1'b1;
          w_rd_next = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (w_adv) begin
          w_load = 1'b1;
          if (r_rd_addr == w_ncbps_rd - AW'(1)) begin
            w_rd_done = 1'b1;
            w_rd_next = RD_IDLE;
          end
        end
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_state  <= RD_IDLE;
      r_rb        <= 1'b0;
      r_rd_addr   <= '0;
      r_out_bits  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sos   <= 1'b0;
      r_out_mod   <= 2'd0;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_load) begin
        r_out_bits  <= w_rd_bit;
        r_out_valid <= 1'b1;
        r_out_sos   <= (r_rd_state == RD_IDLE);
        if (r_rd_state == RD_IDLE) r_out_mod <= w_rd_mod;
        if (w_rd_done) begin
          r_rd_addr <= '0;
          r_rb      <= ~r_rb;
        end else begin
          r_rd_addr <= r_rd_addr + AW'(1);
        end
      end else if (w_adv) begin
        r_out_valid <= 1'b0;
        r_out_sos   <= 1'b0;
      end
    end
  end

  assign in_ready  = !r_full[r_wb];
  assign out_bits  = r_out_bits;
  assign out_valid = r_out_valid;
  assign out_sos   = r_out_sos;
  assign out_mod   = r_out_mod;

endmodule

// File: tb/tb_ofdm_interleaver.sv
// Scoreboard bench for ofdm_interleaver: expected permuted symbols are queued when a symbol
// is driven and compared bit by bit as the DUT hands them off.
module tb_ofdm_interleaver;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mod_sel;
  logic       in_bits;
  logic       in_valid;
  logic       in_ready;
  logic       out_bits;
  logic       out_valid;
  logic       out_ready;
  logic       out_sos;
  logic [1:0] out_mod;
`ifdef ILV_BYPASS_EN
  logic       bypass = 1'b0;
`endif

  ofdm_interleaver dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ILV_BYPASS_EN
    .bypass    (bypass),
`endif
    .mod_sel   (mod_sel),
    .in_bits   (in_bits),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bits  (out_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sos   (out_sos),
    .out_mod   (out_mod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic       sos;
    logic [1:0] mod;
    logic       last;
  } exp_t;

  exp_t sb[$];
  logic tx [1152];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_done = 0;
  int   rd_syms = 0;
  bit   drv_done = 1'b0;
  bit   saw_blk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ncpc_f(input int mod);
    case (mod)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int ncbps_f(input int mod);
    return 192 * ncpc_f(mod);
  endfunction

  // Straight from the 802.16 two-step formula, with real division.
  function automatic int golden_j(input int k, input int mod);
    int n, s, q, r, m;
    n = ncbps_f(mod);
    s = (ncpc_f(mod) / 2 > 1) ? ncpc_f(mod) / 2 : 1;
    q = k / 16;
    r = k % 16;
    m = (n / 16) * r + q;
    return s * (m / s) + ((m + n - (16 * m / n)) % s);
  endfunction

  task automatic push_sym(input int mod);
    logic ex [1152];
    int n;
    n = ncbps_f(mod);
    for (int k = 0; k < n; k++) ex[golden_j(k, mod)] = tx[k];
    for (int j = 0; j < n; j++) sb.push_back('{ex[j], (j == 0), 2'(mod), (j == n - 1)});
  endtask

  task automatic fill_tx(input bit rnd);
    for (int k = 0; k < 1152; k++) tx[k] = rnd ? 1'($urandom) : 1'b0;
  endtask

  task automatic send_sym(input int mod, input int nsend, input bit push, input bit gaps);
    int n, tmo;
    n = ncbps_f(mod);
    if (push) push_sym(mod);
    for (int k = 0; k < nsend; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      tmo = 0;
      do begin
        @(negedge clk);
        mod_sel  = (k == 0) ? 2'(mod) : 2'($urandom);
        in_valid = 1'b1;
        in_bits  = tx[k];
        tmo++;
      end while (!in_ready && tmo < 4000);
      if (!in_ready) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (k == n - 1) wr_done++;
    end
  endtask

  task automatic sink(input int budget, input int rdy_pct);
    exp_t e;
    bit   took;
    int   held;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      held = wr_done - rd_syms - ((out_valid && sb.size() > 0 && sb[0].last) ? 1 : 0);
      chk("in_ready", in_ready, (held < 2));
      if (!in_ready) saw_blk = 1'b1;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      took = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_bit", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_sos_mod_bit", {out_sos, out_mod, out_bits}, {e.sos, e.mod, e.b});
          took = e.last;
        end
      end
      @(posedge clk);
      #1;
      if (took) rd_syms++;
      if (drv_done && sb.size() == 0) break;
    end
    out_ready = 1'b0;
    chk("sb_drained", sb.size(), 32'd0);
    chk("idle_after_drain", out_valid, 1'b0);
  endtask

  task automatic run_sym(input int mod, input int pct);
    drv_done = 1'b0;
    fork
      begin
        send_sym(mod, ncbps_f(mod), 1'b1, 1'b0);
        drv_done = 1'b1;
      end
      sink(20000, pct);
    join
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    mod_sel   = 2'd0;
    in_bits   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bits",  out_bits,  1'b0);
    chk("rst_out_sos",   out_sos,   1'b0);
    chk("rst_out_mod",   out_mod,   2'd0);
    chk("rst_in_ready",  in_ready,  1'b1);

    // 1: BPSK, single one at k=1; also check first-output latency
    fill_tx(1'b0);
    tx[1] = 1'b1;
    send_sym(0, 192, 1'b1, 1'b0);
    chk("lat_before", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_sos",   out_sos,   1'b1);
    drv_done = 1'b1;
    sink(2000, 100);

    // 2: QPSK, single one at k=1
    fill_tx(1'b0);
    tx[1] = 1'b1;
    run_sym(1, 100);

    // 3: 16QAM, ones at k=0 and k=1
    fill_tx(1'b0);
    tx[0] = 1'b1;
    tx[1] = 1'b1;
    run_sym(2, 100);

    // 4: 64QAM, single one at k=1, then random data
    fill_tx(1'b0);
    tx[1] = 1'b1;
    run_sym(3, 100);
    fill_tx(1'b1);
    run_sym(3, 100);

    // 5: four back-to-back symbols, random out_ready and input gaps
    saw_blk  = 1'b0;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          fill_tx(1'b1);
          send_sym((i + 1) % 4, ncbps_f((i + 1) % 4), 1'b1, 1'b1);
        end
        drv_done = 1'b1;
      end
      sink(40000, 40);
    join
    chk("saw_backpressure", saw_blk, 1'b1);

    // 6: reset in the middle of a 64QAM symbol while a 16QAM symbol is held at the output
    fill_tx(1'b1);
    send_sym(2, 768, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_mod",   out_mod,   2'd2);
    fill_tx(1'b1);
    send_sym(3, 100, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_bits",  out_bits,  1'b0);
    chk("midrst_out_sos",   out_sos,   1'b0);
    chk("midrst_out_mod",   out_mod,   2'd0);
    @(negedge clk);
    reset = 1'b0;
    wr_done = 0;
    rd_syms = 0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1'b1);
    fill_tx(1'b1);
    run_sym(3, 70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
